// File: rtl/fp_addsub.sv
// Sequential IEEE-754-style add/subtract with round-to-nearest-even, FTZ inputs and exception flags.
// Latency: done rises after edge 3+k+max(1,n) from the start edge (k align, n normalise shifts), after edge 1 for specials.
// Backpressure: result/flags held in DONE until ack; start is accepted only in IDLE.
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ack,
    input  logic                 sub,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 done,
    output logic                 busy,
    output logic [2:0]           flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW  = MW + 1;             // plus carry-out
    localparam int EW  = EXP_W + 1;          // spare bit catches exponent overflow
    localparam int CAP = MAN_W + 3;
    localparam int CW  = $clog2(MAN_W + 4);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    EXP_MAX  = {1'b0, EXP_ONES};
    localparam logic [EW-1:0]    E_ONE    = EW'(1);
    localparam logic [CW-1:0]    C_ONE    = CW'(1);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, result_q;
    logic           sub_q, sx_q, sy_q, rs_q, uf_q;
    logic [MW-1:0]  mx_q, my_q;
    logic [SW-1:0]  sum_q;
    logic [EW-1:0]  ex_q;
    logic [CW-1:0]  rem_q;
    logic [2:0]     flags_q;

    // Operand decode
    logic [EXP_W-1:0] ea, eb, diff;
    logic [MAN_W-1:0] fa, fb;
    logic             sa, sb, nan_a, nan_b, inf_a, inf_b, a_big, is_nan, special;
    logic [MW-1:0]    ma, mb;
    logic [CW-1:0]    k_c;
    logic [W-1:0]     special_res;

    always_comb begin
        ea      = a_q[W-2 -: EXP_W];
        eb      = b_q[W-2 -: EXP_W];
        fa      = a_q[MAN_W-1:0];
        fb      = b_q[MAN_W-1:0];
        sa      = a_q[W-1];
        sb      = b_q[W-1] ^ sub_q;
        nan_a   = (ea == EXP_ONES) && (fa != '0);
        nan_b   = (eb == EXP_ONES) && (fb != '0);
        inf_a   = (ea == EXP_ONES) && (fa == '0);
        inf_b   = (eb == EXP_ONES) && (fb == '0);
        ma      = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
        mb      = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
        a_big   = (ea >= eb);
        diff    = a_big ? (ea - eb) : (eb - ea);
        k_c     = (int'(diff) > CAP) ? CW'(CAP) : CW'(diff);
        is_nan  = nan_a | nan_b | (inf_a & inf_b & (sa != sb));
        special = nan_a | nan_b | inf_a | inf_b;
        if (is_nan)
            special_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        else if (inf_a)
            special_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else
            special_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    // Magnitude add/subtract; x always holds the larger exponent
    logic [SW-1:0] sum_c;
    logic          sign_c;

    always_comb begin
        sum_c  = '0;
        sign_c = sx_q;
        if (sx_q == sy_q) begin
            sum_c = {1'b0, mx_q} + {1'b0, my_q};
        end else if (mx_q >= my_q) begin
            sum_c  = {1'b0, mx_q - my_q};
            sign_c = (mx_q != my_q) & sx_q;   // exact cancellation gives +0
        end else begin
            sum_c  = {1'b0, my_q - mx_q};
            sign_c = sy_q;
        end
    end

    // Normalisation decisions
    logic [SW-1:0] sum_shl;
    logic [EW-1:0] e_dec;
    logic          norm_zero, norm_carry, norm_ok, norm_uf, norm_exit;

    always_comb begin
        sum_shl    = sum_q << 1;
        e_dec      = ex_q - E_ONE;
        norm_zero  = (sum_q == '0);
        norm_carry = sum_q[SW-1];
        norm_ok    = sum_q[MW-1];
        norm_uf    = (e_dec == '0);
        norm_exit  = norm_zero | norm_carry | norm_ok | norm_uf | sum_shl[MW-1];
    end

    // Round to nearest even on guard/round/sticky
    logic [MAN_W+1:0] m_r;
    logic [MAN_W-1:0] man_out;
    logic [EW-1:0]    e_r;
    logic             rup, ovf;
    logic [W-1:0]     rnd_res;

    always_comb begin
        rup     = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        m_r     = {1'b0, sum_q[MW-1:3]} + (MAN_W+2)'(rup);
        e_r     = m_r[MAN_W+1] ? (ex_q + E_ONE) : ex_q;
        man_out = m_r[MAN_W+1] ? m_r[MAN_W:1] : m_r[MAN_W-1:0];
        ovf     = (e_r >= EXP_MAX);
        if (uf_q)
            rnd_res = {rs_q, {(EXP_W+MAN_W){1'b0}}};
        else if (ovf)
            rnd_res = {rs_q, EXP_ONES, {MAN_W{1'b0}}};
        else
            rnd_res = {rs_q, e_r[EXP_W-1:0], man_out};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = UNPACK;
            UNPACK:  if (special) state_d = DONE;
                     else if (diff != '0) state_d = ALIGN;
                     else state_d = ADD;
            ALIGN:   if (rem_q == C_ONE) state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    if (norm_exit) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            mx_q     <= '0;
            my_q     <= '0;
            ex_q     <= '0;
            rem_q    <= '0;
            sum_q    <= '0;
            rs_q     <= 1'b0;
            uf_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    sub_q <= sub;
                end
                UNPACK: begin
                    uf_q  <= 1'b0;
                    rem_q <= k_c;
                    if (special) begin
                        result_q <= special_res;
                        flags_q  <= {is_nan, 2'b00};
                    end else if (a_big) begin
                        ex_q <= {1'b0, ea};
                        sx_q <= sa;  mx_q <= ma;
                        sy_q <= sb;  my_q <= mb;
                    end else begin
                        ex_q <= {1'b0, eb};
                        sx_q <= sb;  mx_q <= mb;
                        sy_q <= sa;  my_q <= ma;
                    end
                end
                ALIGN: begin
                    // exponent is carried as the larger one; only the mantissa moves
                    my_q  <= {1'b0, my_q[MW-1:2], my_q[1] | my_q[0]};
                    rem_q <= rem_q - C_ONE;
                end
                ADD: begin
                    sum_q <= sum_c;
                    rs_q  <= sign_c;
                end
                NORM: begin
                    if (norm_zero) begin
                        ex_q <= '0;
                    end else if (norm_carry) begin
                        sum_q <= {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                        ex_q  <= ex_q + E_ONE;
                    end else if (!norm_ok) begin
                        if (norm_uf) begin
                            uf_q  <= 1'b1;
                            sum_q <= '0;
                            ex_q  <= '0;
                        end else begin
                            sum_q <= sum_shl;
                            ex_q  <= e_dec;
                        end
                    end
                end
                ROUND: begin
                    result_q <= rnd_res;
                    flags_q  <= {1'b0, ovf & ~uf_q, uf_q};
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE) && (state_q != DONE);

endmodule
